// File: rtl/arith_pkg.sv
// arith_pkg: slice-width and configuration-legality helpers shared by the pipelined adder
package arith_pkg;
  function automatic int slice_width(input int width, input int nstage);
    return nstage < 1 ? width : width / nstage;
  endfunction
  function automatic bit legal_cfg(input int width, input int nstage);
    return nstage >= 1 && nstage <= width && width % nstage == 0;
  endfunction
endpackage

// File: rtl/adder_slice.sv
// adder_slice: combinational SW-bit ripple adder (a, b, ci -> s, co)
module adder_slice #(
  parameter int SW = 4
) (
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          ci,
  output logic [SW-1:0] s,
  output logic          co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, ci};
endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: NSTAGE-deep a+b+cin with valid/ready; ports clk rst in_valid/in_ready a b cin -> out_valid/out_ready sum cout ovf
module pipelined_adder
  import arith_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int NSTAGE = 4,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int SW = slice_width(WIDTH, NSTAGE);
  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] psum;
    logic             carry;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
  } add_token_t;
  add_token_t [NSTAGE-1:0] tok;
  add_token_t [NSTAGE-1:0] nxt;
  add_token_t              last;
  logic                    advance;
  if (!legal_cfg(WIDTH, NSTAGE)) begin : g_bad
    $error("pipelined_adder: WIDTH must be divisible by NSTAGE and 1 <= NSTAGE <= WIDTH");
  end
  assign last     = tok[NSTAGE-1];
  assign advance  = !last.valid || out_ready;
  assign in_ready = advance;
  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    add_token_t       t_in;
    logic [SW-1:0]    s;
    logic             co;
    logic [WIDTH-1:0] s_new;
    if (k == 0) begin : g_first
      assign t_in = '{valid: in_valid, psum: '0, carry: cin, opa: a, opb: b};
    end else begin : g_next
      assign t_in = tok[k-1];
    end
    adder_slice #(.SW(SW)) u_slice (
      .a (t_in.opa[k*SW +: SW]),
      .b (t_in.opb[k*SW +: SW]),
      .ci(t_in.carry),
      .s (s),
      .co(co)
    );
    always_comb begin
      s_new             = t_in.psum;
      s_new[k*SW +: SW] = s;
    end
    assign nxt[k] = '{valid: t_in.valid, psum: s_new, carry: co, opa: t_in.opa, opb: t_in.opb};
  end
  always_ff @(posedge clk)
    if (rst) tok <= '0;
    else if (advance) tok <= nxt;
  assign out_valid = last.valid;
  assign sum       = last.psum;
  assign cout      = last.carry;
  assign ovf       = SIGNED ? (last.opa[WIDTH-1] == last.opb[WIDTH-1]) && (last.psum[WIDTH-1] != last.opa[WIDTH-1])
                            : last.carry;
endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined ripple-carry adder. It computes A+B+Cin over WIDTH bits.
- The carry chain is split into NSTAGE slices, with one register stage per slice.
- Carries one operand set per cycle with a valid/ready handshake and backpressure.
- Sits in the arithmetic datapath library as the throughput successor of the single-bit full-adder cell; the accumulator and MAC blocks instantiate it.

Parameters:
- WIDTH, 16, operand and sum width in bits; must be divisible by NSTAGE.
- NSTAGE, 4, number of pipeline slices (1..WIDTH); also the latency in cycles.
- SIGNED, 0, 1 = the ovf output flags two's-complement overflow; 0 = ovf mirrors cout.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  operands valid this cycle.
- in_ready  output  1  block accepts operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry in.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  (a+b+cin) mod 2^WIDTH.
- cout  output  1  carry out of the MSB.
- ovf  output  1  overflow flag; see SIGNED.

Behaviour:
- Reset (rst=1 at a clk edge):
  - All stage valid bits clear to 0.
  - All stage data registers (partial sums, carries, unconsumed operand bits) clear to 0.
  - Outputs after reset: out_valid=0, sum=0, cout=0, ovf=0, in_ready=1.
  - Reset mid-operation discards every in-flight result; none is emitted afterwards.
- Slicing:
  - SW = WIDTH/NSTAGE.
  - Stage k (k=0..NSTAGE-1) adds bits [k*SW +: SW] of the delayed a and b plus the carry registered from stage k-1.
  - Stage 0 uses cin.
  - Upper operand bits travel with the token, skewed one stage per slice.
- Handshake:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - Stall rule (global, single-enable): advance = !out_valid || out_ready; in_ready = advance.
  - When advance=1, every stage register loads from its predecessor, including bubbles. Stage 0 loads valid = in_valid.
  - When advance=0, all stages hold.
  - No combinational path from in_valid to in_ready. out_ready→in_ready is combinational; this is accepted.
- Latency and throughput:
  - Latency is exactly NSTAGE cycles from an input transfer to out_valid=1, with no stalls.
  - Throughput is one result per cycle.
  - Results emerge in input order; none are dropped or duplicated.
- Stable output: while out_valid=1 && out_ready=0, sum/cout/ovf hold stable.
- Bubbles: the valid bit of an invalid token is 0. Its data contents are don't-care but are still cleared by reset.
- Width rules:
  - sum is truncated to WIDTH bits; cout = bit WIDTH of the full sum.
  - SIGNED=1: ovf = (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]), using the operands belonging to the same token. cin participates in the sum.
  - SIGNED=0: ovf = cout.
- Boundary cases:
  - NSTAGE=1: single register stage, latency 1.
  - NSTAGE=WIDTH: SW=1; each slice is a single full-adder bit.
  - Simultaneous input accept and output drain in the same cycle is legal and sustains full rate.
  - in_valid with rst=1: the input is ignored.

Decomposition:
- Package arith_pkg holds:
  - localparam functions for SW and parameter legality checks (elaboration $error if WIDTH % NSTAGE != 0 or NSTAGE < 1).
  - typedef add_token_t {valid, partial sum, carry, remaining a/b bits}. The struct is parametrised via the module; the package holds only the helpers.
- One natural sub-module, adder_slice: combinational SW-bit ripple adder (a, b, ci → s, co), instantiated NSTAGE times. All registers and handshake logic live in pipelined_adder.

Test Plan:
- Reset check: hold rst=1 for 3 cycles with in_valid=1 → out_valid=0, sum=0, cout=0, ovf=0, in_ready=1 throughout. After release, first out_valid comes 4 cycles after the first accepted input.
- Single op (WIDTH=16, NSTAGE=4, SIGNED=0): a=16'h00FF, b=16'h0001, cin=0 → 4 cycles later sum=16'h0100, cout=0, ovf=0. Confirms carry crossing the slice-0→1 boundary.
- Full carry ripple: a=16'hFFFF, b=16'h0000, cin=1 → sum=16'h0000, cout=1, ovf=1.
- Signed overflow (SIGNED=1): a=16'h7FFF, b=16'h0001 → sum=16'h8000, cout=0, ovf=1. a=16'h8000, b=16'hFFFF → sum=16'h7FFF, cout=1, ovf=1.
- Backpressure: stream 10 random ops back-to-back; hold out_ready=0 for cycles 5–8.
  - in_ready must be 0 in those cycles.
  - Outputs hold stable.
  - All 10 results match the reference model, in order, none lost or duplicated.
- Mid-flight reset: accept 3 ops, assert rst for 1 cycle at cycle 2 → no out_valid for any of the 3 ops. A new op after reset completes with latency 4. Repeat the random stream at NSTAGE=1 and NSTAGE=16.
